if_fetch_queue: RTL



---
 rtl/if_fetch_queue.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the PC and issues one fetch at a time.
// Optional static prediction enabled by defining IF_STATIC_PREDICT_EN.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_DEPTH = 4,
  parameter int          IQ_AW    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_req_ready,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_instr,
  input  logic        jump_valid,
  input  logic [31:0] jump_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_pred_taken,
  input  logic        issue_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  localparam logic [IQ_AW:0]   DEPTH_C = (IQ_AW+1)'(IQ_DEPTH);
  localparam logic [IQ_AW:0]   CNT_ONE = (IQ_AW+1)'(1);
  localparam logic [IQ_AW-1:0] PTR_ONE = IQ_AW'(1);

  state_t state_q;
  state_t state_d;

  logic [31:0] pc_q;
  logic [31:0] q_instr [IQ_DEPTH];
  logic [31:0] q_pc    [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] q_pred;

  logic [IQ_AW-1:0] head_q;
  logic [IQ_AW-1:0] tail_q;
  logic [IQ_AW:0]   cnt_q;

  logic        req_ok;
  logic        fire;
  logic        resp;
  logic        push;
  logic        pop;
  logic        has_head;
  logic [31:0] npc;
  logic        npred;

`ifdef IF_STATIC_PREDICT_EN
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic        is_jal;
  logic        is_bbr;

  // Static next-PC guess for the returning instruction
  always_comb begin
    j_imm  = {{12{ic_resp_instr[31]}}, ic_resp_instr[19:12],
              ic_resp_instr[20], ic_resp_instr[30:21], 1'b0};
    b_imm  = {{20{ic_resp_instr[31]}}, ic_resp_instr[7],
              ic_resp_instr[30:25], ic_resp_instr[11:8], 1'b0};
    is_jal = (ic_resp_instr[6:0] == 7'b1101111);
    is_bbr = (ic_resp_instr[6:0] == 7'b1100011)
           & ic_resp_instr[31];
    npc    = pc_q + 32'd4;
    npred  = 1'b0;
    unique case (1'b1)
      is_jal: begin
        npc   = pc_q + j_imm;
        npred = 1'b1;
      end
      is_bbr: begin
        npc   = pc_q + b_imm;
        npred = 1'b1;
      end
      default: ;
    endcase
  end
`else
  assign npc   = pc_q + 32'd4;
  assign npred = 1'b0;
`endif

  assign has_head = (cnt_q != '0);
  assign req_ok   = rst_in & rdy_in & (state_q == S_IDLE)
                  & (cnt_q < DEPTH_C) & ~jump_valid;
  assign fire     = req_ok & ic_req_ready;
  assign resp     = rdy_in & ic_resp_valid;
  assign push     = resp & (state_q == S_WAIT) & ~jump_valid;
  assign pop      = rdy_in & has_head & issue_ready & ~jump_valid;

  assign ic_req_valid     = req_ok;
  assign ic_req_addr      = pc_q;
  assign instr_valid      = rdy_in & has_head;
  assign instr            = q_instr[head_q];
  assign instr_pc         = q_pc[head_q];
  assign instr_pred_taken = q_pred[head_q];

  // Fetch FSM next state; a redirect makes an in-flight response stale
  always_comb begin
    state_d = state_q;
    if (jump_valid) begin
      if (resp)
        state_d = S_IDLE;
      else if (state_q == S_WAIT)
        state_d = S_DROP;
    end else begin
      unique case (state_q)
        S_IDLE: if (fire) state_d = S_WAIT;
        S_WAIT: if (resp) state_d = S_IDLE;
        S_DROP: if (resp) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, PC and queue pointers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      if (jump_valid) begin
        pc_q   <= jump_pc;
        head_q <= tail_q;
        cnt_q  <= '0;
      end else begin
        if (push) begin
          pc_q   <= npc;
          tail_q <= tail_q + PTR_ONE;
        end
        if (pop)
          head_q <= head_q + PTR_ONE;
        unique case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CNT_ONE;
          2'b01:   cnt_q <= cnt_q - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

  // Queue storage, written at the tail on each accepted response
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
      q_pred <= '0;
    end else if (push) begin
      q_instr[tail_q] <= ic_resp_instr;
      q_pc[tail_q]    <= pc_q;
      q_pred[tail_q]  <= npred;
    end
  end

endmodule
